word_gen_dispatch: RTL and testbench

//  Scheduler between word_gen_b_varlen output storage and N hash-unit input buffers.

---
 rtl/word_gen_dispatch.sv | 145 ++++++++++++++
 tb/tb_word_gen_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_gen_dispatch.sv
// Copies each candidate word out of the shared word_gen storage into one of N hash-unit
// input buffers, chosen round-robin among units that are not full, and forwards its header.
module word_gen_dispatch #(
   parameter int N_UNITS      = 4,
   parameter int WORD_MAX_LEN = 32,
   localparam int AW = $clog2(WORD_MAX_LEN),
   localparam int LW = $clog2(WORD_MAX_LEN + 1),
   localparam int IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [7:0]         gen_dout,
   output logic [AW-1:0]      gen_rd_addr,
   input  logic               gen_empty,
   output logic               gen_set_empty,
   input  logic [15:0]        gen_pkt_id,
   input  logic [15:0]        gen_word_id,
   input  logic [31:0]        gen_gen_id,
   input  logic [LW-1:0]      gen_word_len,
   input  logic               gen_end,
   input  logic [N_UNITS-1:0] unit_full,
   output logic [N_UNITS-1:0] unit_wr_en,
   output logic [AW-1:0]      unit_addr,
   output logic [7:0]         unit_din,
   output logic [N_UNITS-1:0] unit_set_full,
   output logic [15:0]        unit_pkt_id,
   output logic [15:0]        unit_word_id,
   output logic [31:0]        unit_gen_id,
   output logic [LW-1:0]      unit_word_len,
   output logic               list_done,
   output logic               idle,
   output logic [2:0]         fsm_state
);

   // Handshakes: a word is offered while gen_empty=0 and is taken back by a one-cycle
   // gen_set_empty; a unit accepts a word only while unit_full=0 (sampled in SELECT) and
   // the word is handed over by a one-cycle unit_set_full on the granted unit.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_COPY    = 3'd2,
      S_COMMIT  = 3'd3,
      S_COMMIT0 = 3'd4,
      S_DONE    = 3'd5,
      S_GAP     = 3'd6
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        cand;
   logic                 pick_found;
   logic [N_UNITS-1:0]   grant;
   logic                 wr_pend;
   logic                 last_addr;

   // Scan from the farthest candidate to the nearest so the nearest free unit wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = N_UNITS; k >= 1; k--) begin
         cand = IW'((int'(rr_ptr) + k) % N_UNITS);
         if (!unit_full[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign last_addr = (LW'(gen_rd_addr) == (unit_word_len - LW'(1)));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!gen_empty) begin
               state_nxt = gen_end ? S_DONE : S_SELECT;
            end
         end
         S_SELECT: begin
            if (pick_found) begin
               state_nxt = (gen_word_len == '0) ? S_COMMIT0 : S_COPY;
            end
         end
         S_COPY: begin
            if (last_addr) begin
               state_nxt = S_COMMIT;
            end
         end
         S_COMMIT, S_COMMIT0, S_DONE: state_nxt = S_GAP;
         S_GAP:                       state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
   end

   // Read data lags the address by one cycle, so the write strobe and byte address are
   // the COPY-cycle values delayed by one register stage.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rr_ptr        <= IW'(N_UNITS - 1);
         grant         <= '0;
         gen_rd_addr   <= '0;
         unit_addr     <= '0;
         wr_pend       <= 1'b0;
         unit_pkt_id   <= '0;
         unit_word_id  <= '0;
         unit_gen_id   <= '0;
         unit_word_len <= '0;
      end else begin
         wr_pend <= (state == S_COPY);
         if (state == S_SELECT && pick_found) begin
            grant         <= N_UNITS'(1) << pick_idx;
            rr_ptr        <= pick_idx;
            gen_rd_addr   <= '0;
            unit_pkt_id   <= gen_pkt_id;
            unit_word_id  <= gen_word_id;
            unit_gen_id   <= gen_gen_id;
            unit_word_len <= gen_word_len;
         end
         if (state == S_COPY) begin
            gen_rd_addr <= gen_rd_addr + AW'(1);
            unit_addr   <= gen_rd_addr;
         end
      end
   end

   assign unit_wr_en    = wr_pend ? grant : '0;
   assign unit_set_full = (state == S_COMMIT || state == S_COMMIT0) ? grant : '0;
   assign unit_din      = gen_dout;
   assign gen_set_empty = (state == S_COMMIT) || (state == S_COMMIT0) || (state == S_DONE);
   assign list_done     = (state == S_DONE);
   assign idle          = (state == S_IDLE);
   assign fsm_state     = state;

endmodule

// File: tb/tb_word_gen_dispatch.sv
// Bench for word_gen_dispatch: models the word storage and the unit buffers, and checks
// grants, byte streams, headers and timing against an expected-word scoreboard.
module tb_word_gen_dispatch;

   localparam int N  = 4;
   localparam int WL = 32;

   logic        CLK;
   logic        RESET_N;
   logic [7:0]  gen_dout;
   logic [4:0]  gen_rd_addr;
   logic        gen_empty;
   logic        gen_set_empty;
   logic [15:0] gen_pkt_id;
   logic [15:0] gen_word_id;
   logic [31:0] gen_gen_id;
   logic [5:0]  gen_word_len;
   logic        gen_end;
   logic [3:0]  unit_full;
   logic [3:0]  unit_wr_en;
   logic [4:0]  unit_addr;
   logic [7:0]  unit_din;
   logic [3:0]  unit_set_full;
   logic [15:0] unit_pkt_id;
   logic [15:0] unit_word_id;
   logic [31:0] unit_gen_id;
   logic [5:0]  unit_word_len;
   logic        list_done;
   logic        idle;
   logic [2:0]  fsm_state;

   word_gen_dispatch #(.N_UNITS(N), .WORD_MAX_LEN(WL)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .gen_dout(gen_dout), .gen_rd_addr(gen_rd_addr),
      .gen_empty(gen_empty), .gen_set_empty(gen_set_empty), .gen_pkt_id(gen_pkt_id),
      .gen_word_id(gen_word_id), .gen_gen_id(gen_gen_id), .gen_word_len(gen_word_len),
      .gen_end(gen_end), .unit_full(unit_full), .unit_wr_en(unit_wr_en),
      .unit_addr(unit_addr), .unit_din(unit_din), .unit_set_full(unit_set_full),
      .unit_pkt_id(unit_pkt_id), .unit_word_id(unit_word_id), .unit_gen_id(unit_gen_id),
      .unit_word_len(unit_word_len), .list_done(list_done), .idle(idle),
      .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- storage model: registered read ----------------
   logic [7:0] mem [0:WL-1];
   always @(posedge CLK) gen_dout <= mem[gen_rd_addr];

   // ---------------- scoreboard ----------------
   // exp_q entry: {unit[3:0], len[5:0], gen_id[31:0], word_id[15:0], pkt_id[15:0]}
   logic [73:0]  exp_q[$];
   logic [255:0] dat_q[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int empty_cnt = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- unit buffer monitor ----------------
   logic [7:0]  ubuf [N][WL];
   int          wr_cnt [N];
   int          nxt_addr [N];
   int          m_wu, m_su, m_len;
   logic [73:0]  m_e;
   logic [255:0] m_d;
   bit          m_bad;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         for (int u = 0; u < N; u++) begin
            wr_cnt[u]   = 0;
            nxt_addr[u] = 0;
         end
      end else begin
         if (unit_wr_en != 4'b0) begin
            check("wr_onehot", $countones(unit_wr_en) == 1, 1'b1);
            m_wu = 0;
            for (int i = 0; i < N; i++) if (unit_wr_en[i]) m_wu = i;
            check("wr_addr", unit_addr, nxt_addr[m_wu]);
            ubuf[m_wu][unit_addr] = unit_din;
            nxt_addr[m_wu]++;
            wr_cnt[m_wu]++;
         end
         if (gen_set_empty) empty_cnt++;
         if (unit_set_full != 4'b0) begin
            check("set_full_with_set_empty", gen_set_empty, 1'b1);
            if (exp_q.size() == 0) begin
               check("unexpected_set_full", unit_set_full, 4'b0);
            end else begin
               m_e   = exp_q.pop_front();
               m_d   = dat_q.pop_front();
               m_len = int'(m_e[69:64]);
               check("set_full_unit", unit_set_full, 4'b1 << m_e[73:70]);
               check("wr_at_commit", unit_wr_en, (m_len == 0) ? 4'b0 : (4'b1 << m_e[73:70]));
               check("header", {unit_word_len, unit_gen_id, unit_word_id, unit_pkt_id}, m_e[69:0]);
               m_su = int'(m_e[73:70]);
               check("wr_count", wr_cnt[m_su], m_len);
               m_bad = 1'b0;
               for (int i = 0; i < m_len; i++) if (ubuf[m_su][i] !== m_d[i*8 +: 8]) m_bad = 1'b1;
               check("word_bytes", m_bad, 1'b0);
               wr_cnt[m_su]   = 0;
               nxt_addr[m_su] = 0;
            end
         end
         if (list_done) begin
            done_cnt++;
            check("done_set_empty", gen_set_empty, 1'b1);
            check("done_no_strobe", {unit_wr_en, unit_set_full}, 8'h00);
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [73:0]  cur_e;
   logic [255:0] cur_d;

   function automatic int pick_unit(input int last, input logic [3:0] full);
      for (int k = 1; k <= N; k++) begin
         if (!full[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_addr"}, gen_rd_addr, 5'd0);
      check({tag, "_unit_addr"}, unit_addr, 5'd0);
      check({tag, "_strobes"}, {unit_wr_en, unit_set_full, gen_set_empty, list_done}, 10'd0);
      check({tag, "_idle"}, idle, 1'b1);
      check({tag, "_headers"}, {unit_word_len, unit_gen_id, unit_word_id, unit_pkt_id}, 70'd0);
   endtask

   task automatic do_reset();
      RESET_N   = 1'b0;
      gen_empty = 1'b1;
      gen_end   = 1'b0;
      repeat (2) @(negedge CLK);
      check_reset_vals("reset");
      exp_q.delete();
      dat_q.delete();
      RESET_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic push_exp();
      exp_q.push_back(cur_e);
      dat_q.push_back(cur_d);
   endtask

   task automatic present_word(input int len, input logic is_end, input logic [255:0] data,
                               input int unit);
      for (int i = 0; i < WL; i++) mem[i] = data[i*8 +: 8];
      @(negedge CLK);
      gen_pkt_id   = 16'($urandom);
      gen_word_id  = 16'($urandom);
      gen_gen_id   = $urandom;
      gen_word_len = 6'(len);
      gen_end      = is_end;
      gen_empty    = 1'b0;
      cur_e = {4'(unit), 6'(len), gen_gen_id, gen_word_id, gen_pkt_id};
      cur_d = data;
      if (!is_end) push_exp();
   endtask

   task automatic finish_word(input int exp_busy, output int first_wr);
      int  busy;
      int  cyc;
      bit  seen;
      busy = 0;
      cyc = 0;
      seen = 1'b0;
      first_wr = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         cyc++;
         if (!idle) busy++;
         if (unit_wr_en != 4'b0 && first_wr < 0) first_wr = cyc;
         if (gen_set_empty) begin
            seen = 1'b1;
            gen_empty = 1'b1;
         end
         if (seen && idle) break;
      end
      check("set_empty_seen", seen, 1'b1);
      if (exp_busy >= 0) check("busy_cycles", busy, exp_busy);
      check("sb_drained", exp_q.size(), 0);
   endtask

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      int fw;
      int last;
      int len;
      int d0;
      int e0;
      bit hit;
      logic [3:0] full;
      logic [255:0] abc;

      RESET_N      = 1'b0;
      gen_empty    = 1'b1;
      gen_end      = 1'b0;
      gen_pkt_id   = '0;
      gen_word_id  = '0;
      gen_gen_id   = '0;
      gen_word_len = '0;
      unit_full    = 4'b0;
      for (int i = 0; i < WL; i++) mem[i] = 8'h00;
      abc = '0;
      abc[23:0] = {8'h63, 8'h62, 8'h61};

      // 1: three "abc" words, all units free
      do_reset();
      for (int w = 0; w < 3; w++) begin
         present_word(3, 1'b0, abc, w);
         finish_word(6, fw);
         check("abc_first_write", fw, 3);
      end

      // 2: unit 1 full -> 0,2,3,0, then unit 1 freed -> 1
      do_reset();
      unit_full = 4'b0010;
      present_word(4, 1'b0, rand_data(), 0); finish_word(7, fw);
      present_word(5, 1'b0, rand_data(), 2); finish_word(8, fw);
      present_word(2, 1'b0, rand_data(), 3); finish_word(5, fw);
      present_word(7, 1'b0, rand_data(), 0); finish_word(10, fw);
      unit_full = 4'b0000;
      present_word(3, 1'b0, rand_data(), 1); finish_word(6, fw);

      // 3: all units full for 20 cycles, then unit 3 freed
      do_reset();
      unit_full = 4'b1111;
      e0 = empty_cnt;
      present_word(4, 1'b0, rand_data(), 3);
      hit = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (unit_wr_en != 4'b0 || unit_set_full != 4'b0 || gen_set_empty) hit = 1'b1;
      end
      check("stall_quiet", hit, 1'b0);
      check("stall_no_set_empty", empty_cnt - e0, 0);
      unit_full = 4'b0111;
      finish_word(-1, fw);
      check("unfull_first_write", fw, 2);
      unit_full = 4'b0000;

      // 4: zero-length and maximum-length words
      do_reset();
      present_word(0, 1'b0, rand_data(), 0);
      finish_word(3, fw);
      check("len0_no_write", fw, -1);
      present_word(32, 1'b0, rand_data(), 1);
      finish_word(35, fw);

      // 5: end-of-list dummy
      d0 = done_cnt;
      e0 = empty_cnt;
      present_word(0, 1'b1, rand_data(), 0);
      finish_word(2, fw);
      check("list_done_pulses", done_cnt - d0, 1);
      check("dummy_set_empty", empty_cnt - e0, 1);
      check("dummy_no_write", fw, -1);

      // 6: reset during byte 5 of a 10-byte word
      do_reset();
      e0 = empty_cnt;
      present_word(10, 1'b0, rand_data(), 0);
      hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (unit_wr_en[0] && unit_addr == 5'd5) begin
            hit = 1'b1;
            break;
         end
      end
      check("reached_byte5", hit, 1'b1);
      RESET_N = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(posedge CLK);
      #1;
      check_reset_vals("midreset_edge");
      check("midreset_no_set_empty", empty_cnt - e0, 0);
      exp_q.delete();
      dat_q.delete();
      @(negedge CLK);
      RESET_N = 1'b1;
      push_exp();
      finish_word(13, fw);
      check("resend_first_write", fw, 3);

      // random words against the round-robin reference
      last = 0;
      for (int w = 0; w < 12; w++) begin
         full = 4'($urandom_range(0, 14));
         len  = $urandom_range(0, WL);
         last = pick_unit(last, full);
         unit_full = full;
         present_word(len, 1'b0, rand_data(), last);
         finish_word((len == 0) ? 3 : len + 3, fw);
      end
      unit_full = 4'b0000;

      repeat (3) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
